// File: rtl/jtframe_ba_arbiter.sv
// jtframe_ba_arbiter
// Shares one SDRAM bank port among N requesters. One transaction is granted at a
// time. The bank handshake strobes (ack/dst/rdy) are routed only to the current
// owner. A hung transaction, where rdy never arrives, is aborted after TOUT cycles
// so the bank cannot lock up.
//
// Build option: define JTFRAME_ARB_RR_EN for round-robin arbitration. The search
// starts at owner+1. Without it, fixed priority applies and the lowest index wins.
//
// Ports
//   clk, rst          SDRAM clock, synchronous active-high reset
//   req_addr/din/...  packed requester buses, requester k at slice k
//   req_rd/req_wr     request levels, one bit per requester
//   req_ack/dst/rdy   handshake strobes routed to the owner only
//   ba_*              bank side: address/data/mask mux, rd/wr out, ack/dst/rdy in
//   owner             current or last grantee
//   busy              a transaction is in progress
//   tout_err          high during the DATA cycle in which a timeout abort happens
module jtframe_ba_arbiter #(
    parameter int N    = 3,
    parameter int AW   = 22,
    parameter int OW   = 2,
    parameter int TOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N-1:0]    req_rd,
    input  logic [N-1:0]    req_wr,
    input  logic [N*16-1:0] req_din,
    input  logic [N*2-1:0]  req_din_m,
    output logic [N-1:0]    req_ack,
    output logic [N-1:0]    req_dst,
    output logic [N-1:0]    req_rdy,
    output logic [AW-1:0]   ba_addr,
    output logic            ba_rd,
    output logic            ba_wr,
    output logic [15:0]     ba_din,
    output logic [1:0]      ba_din_m,
    input  logic            ba_ack,
    input  logic            ba_dst,
    input  logic            ba_rdy,
    output logic [OW-1:0]   owner,
    output logic            busy,
    output logic            tout_err
);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t          state_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   winner_d;
    logic [7:0]      cnt_q;

    logic [AW-1:0]   addr_a [N];
    logic [15:0]     din_a  [N];
    logic [1:0]      msk_a  [N];
    logic [N-1:0]    own_hot;
    logic [N-1:0]    req_any;
    logic [N-1:0]    cand;
    logic            found;
    int              off;

    // Unpack the requester buses and decode the owner as a one-hot mask
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign addr_a[gi]  = req_addr[gi*AW +: AW];
        assign din_a[gi]   = req_din[gi*16 +: 16];
        assign msk_a[gi]   = req_din_m[gi*2 +: 2];
        assign own_hot[gi] = (owner_q == OW'(gi));
    end

    assign req_any = req_rd | req_wr;

    logic own_rd, own_wr, st_req, st_data, tout_hit, live;
    assign own_rd   = |(req_rd & own_hot);
    assign own_wr   = |(req_wr & own_hot);
    assign st_req   = (state_q == REQ);
    assign st_data  = (state_q == DATA);
    // cnt_q is 0 in the first DATA cycle, so TOUT-1 marks the TOUT-th cycle
    assign tout_hit = (cnt_q == 8'(TOUT - 1));
    // Strobes are cut while reset is held so an abandoned access is not reported
    assign live     = ~rst;

`ifdef JTFRAME_ARB_RR_EN
    logic [2*N-1:0] dbl;
`endif

    // Winner search. The candidate vector is rotated so that bit 0 is the first
    // index to consider. The first set bit then gives the offset of the winner.
    always_comb begin
        found = 1'b0;
        off   = 0;
`ifdef JTFRAME_ARB_RR_EN
        dbl  = {req_any, req_any} >> (int'(owner_q) + 1);
        cand = dbl[N-1:0];
`else
        cand = req_any;
`endif
        for (int i = 0; i < N; i++) begin
            if (!found && cand[0]) begin
                off   = i;
                found = 1'b1;
            end
            cand = cand >> 1;
        end
`ifdef JTFRAME_ARB_RR_EN
        winner_d = OW'((int'(owner_q) + 1 + off) % N);
`else
        winner_d = OW'(off);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_any) begin
                        owner_q <= winner_d;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ba_ack) begin
                        cnt_q   <= '0;
                        // ack and rdy together: the access completes at once
                        state_q <= ba_rdy ? IDLE : DATA;
                    end else if (!own_rd && !own_wr) begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (ba_rdy || tout_hit) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bank side. A write wins over a read when both are requested.
    assign ba_addr  = addr_a[owner_q];
    assign ba_din   = din_a[owner_q];
    assign ba_din_m = msk_a[owner_q];
    assign ba_wr    = st_req & own_wr;
    assign ba_rd    = st_req & own_rd & ~own_wr;

    // Requester side. Strobes arriving in the wrong phase are dropped.
    assign req_ack  = own_hot & {N{live & ba_ack & st_req}};
    assign req_dst  = own_hot & {N{live & ba_dst & st_data}};
    assign req_rdy  = own_hot & {N{live & ba_rdy & (st_data | (st_req & ba_ack))}};

    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);
    assign tout_err = live & st_data & tout_hit & ~ba_rdy;

endmodule

// File: tb/tb_jtframe_ba_arbiter.sv
module tb_jtframe_ba_arbiter;
    localparam int N    = 3;
    localparam int AW   = 22;
    localparam int OW   = 2;
    localparam int TOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]   addr_v [N];
    logic [15:0]     din_v  [N];
    logic [1:0]      msk_v  [N];
    logic [N-1:0]    rd_v, wr_v;
    logic [N*AW-1:0] req_addr;
    logic [N*16-1:0] req_din;
    logic [N*2-1:0]  req_din_m;
    logic [N-1:0]    req_ack, req_dst, req_rdy;
    logic [AW-1:0]   ba_addr;
    logic            ba_rd, ba_wr;
    logic [15:0]     ba_din;
    logic [1:0]      ba_din_m;
    logic            ba_ack, ba_dst, ba_rdy;
    logic [OW-1:0]   owner;
    logic            busy, tout_err;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_addr[gi*AW +: AW] = addr_v[gi];
        assign req_din[gi*16 +: 16]  = din_v[gi];
        assign req_din_m[gi*2 +: 2]  = msk_v[gi];
    end

    jtframe_ba_arbiter #(.N(N), .AW(AW), .OW(OW), .TOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_rd(rd_v), .req_wr(wr_v),
        .req_din(req_din), .req_din_m(req_din_m),
        .req_ack(req_ack), .req_dst(req_dst), .req_rdy(req_rdy),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr),
        .ba_din(ba_din), .ba_din_m(ba_din_m),
        .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
        .owner(owner), .busy(busy), .tout_err(tout_err)
    );

    int checks = 0;
    int errors = 0;
    int last_owner = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Arbitration rule: round-robin starts after the last grantee, otherwise lowest index
    function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef JTFRAME_ARB_RR_EN
        for (int d = 1; d <= N; d++) begin
            int k;
            k = (last + d) % N;
            if (r[k]) return k;
        end
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int k);
        return N'(1) << k;
    endfunction

    task automatic randomize_buses;
        for (int k = 0; k < N; k++) begin
            addr_v[k] = AW'($urandom);
            din_v[k]  = 16'($urandom);
            msk_v[k]  = 2'($urandom);
        end
    endtask

    // Idle-cycle checks; returns the requester the model expects to win
    task automatic idle_check(output int w);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_rdwr", {ba_rd, ba_wr}, 0);
        chk("idle_addr", ba_addr, addr_v[last_owner]);
        w = pick(rd_v | wr_v, last_owner);
        if (w < 0) chk("no_request", 1, 0);
    endtask

    task automatic req_check(input int w);
        chk("req_busy", busy, 1);
        chk("req_owner", owner, w);
        chk("req_addr", ba_addr, addr_v[w]);
        chk("req_din", ba_din, din_v[w]);
        chk("req_dinm", ba_din_m, msk_v[w]);
        chk("req_wr", ba_wr, wr_v[w]);
        chk("req_rd", ba_rd, rd_v[w] & ~wr_v[w]);
    endtask

    // Full transaction from an idle cycle whose requests the caller has set
    task automatic txn(input int ack_dly, input int rdy_dly, input bit hold);
        int w;
        idle_check(w);
        if (w >= 0) begin
            for (int c = 0; c <= ack_dly; c++) begin
                tick;
                ba_ack = (c == ack_dly);
                ba_dst = (c != ack_dly) ? 1'($urandom) : 1'b0;
                #1;
                req_check(w);
                chk("req_ack", req_ack, (c == ack_dly) ? oh(w) : '0);
                chk("req_dst_in_req", req_dst, 0);
            end
            tick;
            ba_ack = 1'b0;
            if (!hold) begin
                rd_v[w] = 1'b0;
                wr_v[w] = 1'b0;
            end
            for (int c = 0; c <= rdy_dly; c++) begin
                if (c > 0) tick;
                ba_dst = (c == 0);
                ba_rdy = (c == rdy_dly);
                #1;
                chk("data_rdwr", {ba_rd, ba_wr}, 0);
                chk("data_busy", busy, 1);
                chk("data_dst", req_dst, (c == 0) ? oh(w) : '0);
                chk("data_rdy", req_rdy, (c == rdy_dly) ? oh(w) : '0);
                chk("data_tout", tout_err, 0);
            end
            tick;
            ba_rdy = 1'b0;
            ba_dst = 1'b0;
            rd_v[w] = 1'b0;
            wr_v[w] = 1'b0;
            last_owner = w;
            $display("txn owner=%0d ack_dly=%0d rdy_dly=%0d", w, ack_dly, rdy_dly);
        end
    endtask

    task automatic grant_and_ack(input int exp_w);
        int w;
        idle_check(w);
        chk("grant_model", w, exp_w);
        tick;
        ba_ack = 1'b1;
        #1;
        chk("ga_owner", owner, exp_w);
        chk("ga_ack", req_ack, oh(exp_w));
        tick;
        ba_ack = 1'b0;
        last_owner = exp_w;
    endtask

    // Withhold rdy (or give it in the last allowed cycle), then abort a REQ
    task automatic tout_run(input bit rdy_last);
        int w;
        rd_v = 3'b010;
        wr_v = '0;
        grant_and_ack(1);
        rd_v = 3'b001;
        for (int c = 1; c <= TOUT; c++) begin
            if (c > 1) tick;
            ba_rdy = rdy_last && (c == TOUT);
            #1;
            chk("tout_err", tout_err, (c == TOUT) && !rdy_last);
            chk("tout_busy", busy, 1);
            chk("tout_rdy", req_rdy, (c == TOUT && rdy_last) ? oh(1) : '0);
        end
        tick;
        ba_rdy = 1'b0;
        #1;
        chk("tout_busy_fall", busy, 0);
        chk("tout_err_clr", tout_err, 0);
        w = pick(rd_v | wr_v, last_owner);
        tick;
        #1;
        chk("pending_owner", owner, w);
        chk("pending_rd", ba_rd, 1);
        last_owner = w;
        rd_v = '0;
        #1;
        chk("abort_ack", req_ack, 0);
        tick;
        ba_dst = 1'b1;
        #1;
        chk("abort_idle", busy, 0);
        chk("stray_dst", req_dst, 0);
        ba_dst = 1'b0;
        $display("timeout run rdy_last=%0d", rdy_last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_v = '0; wr_v = '0;
        ba_ack = 1'b0; ba_dst = 1'b0; ba_rdy = 1'b0;
        randomize_buses();
        repeat (3) tick;
        rst = 1'b0;
        ba_ack = 1'b1; ba_dst = 1'b1; ba_rdy = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_addr", ba_addr, addr_v[0]);
        chk("rst_din", ba_din, din_v[0]);
        chk("rst_rdwr", {ba_rd, ba_wr}, 0);
        chk("rst_strobes", {req_ack, req_dst, req_rdy}, 0);
        chk("rst_tout", tout_err, 0);
        ba_ack = 1'b0; ba_dst = 1'b0; ba_rdy = 1'b0;
        $display("reset checked");
        tick;

        // Single read from requester 1
        addr_v[1] = 22'h12345;
        rd_v = 3'b010;
        txn(1, 2, 1'b0);

        // Requesters 0 and 2 request back to back
        for (int i = 0; i < 4; i++) begin
            randomize_buses();
            rd_v[0] = 1'b1;
            rd_v[2] = 1'b1;
            txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'b1);
        end
        rd_v = '0;

        // Write wins over read
        din_v[2] = 16'hBEEF;
        msk_v[2] = 2'b01;
        rd_v = 3'b100;
        wr_v = 3'b100;
        txn(0, 1, 1'b1);

        // Ack and rdy in the same REQ cycle
        rd_v = 3'b100;
        begin
            int w;
            idle_check(w);
            chk("ackrdy_model", w, 2);
        end
        tick;
        ba_ack = 1'b1;
        ba_rdy = 1'b1;
        #1;
        chk("ackrdy_ack", req_ack, oh(2));
        chk("ackrdy_rdy", req_rdy, oh(2));
        tick;
        ba_ack = 1'b0;
        ba_rdy = 1'b0;
        rd_v = '0;
        #1;
        chk("ackrdy_idle", busy, 0);
        last_owner = 2;
        $display("ack+rdy in REQ owner=2");

        tout_run(1'b0);
        tout_run(1'b1);

        // Random traffic
        for (int i = 0; i < 20; i++) begin
            randomize_buses();
            rd_v = 3'($urandom);
            wr_v = 3'($urandom);
            if ((rd_v | wr_v) == '0) rd_v[$urandom_range(0, N - 1)] = 1'b1;
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 1'($urandom));
        end
        rd_v = '0;
        wr_v = '0;

        // Reset while in DATA
        randomize_buses();
        rd_v = 3'b100;
        grant_and_ack(pick(3'b100, last_owner));
        rd_v = '0;
        rst = 1'b1;
        ba_rdy = 1'b1;
        #1;
        chk("rst_cycle_rdy", req_rdy, 0);
        tick;
        rst = 1'b0;
        ba_ack = 1'b1;
        ba_dst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_addr", ba_addr, addr_v[0]);
        chk("midrst_strobes", {req_ack, req_dst, req_rdy}, 0);
        chk("midrst_tout", tout_err, 0);
        ba_ack = 1'b0; ba_dst = 1'b0; ba_rdy = 1'b0;
        last_owner = 0;
        $display("reset in DATA checked");
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
